// File: rtl/das_trace_capture.sv
// das_trace_capture: trigger-aligned ADC trace capture.
// On each accepted trigger rising edge, waits DELAY samples, captures
// TRACE_LEN samples into a FIFO and streams them out on valid/ready with a
// last marker on the final sample of each trace.
// Optional feature macro: DAS_TRACE_CAPTURE_SIGNED_EN (offset binary to
// sign-extended two's complement output); default is zero-extension.
module das_trace_capture #(
   parameter int ADC_W      = 14,
   parameter int TRACE_LEN  = 1024,
   parameter int DELAY      = 0,
   parameter int FIFO_DEPTH = 2048
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [ADC_W-1:0] adc_data_i,
   input  logic             trig_i,
   output logic [15:0]      m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic             m_last_o,
   output logic             busy_o,
   output logic [15:0]      trig_miss_cnt_o
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (DELAY > TRACE_LEN) ? DELAY : TRACE_LEN;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] DLY_LAST = CW'((DELAY > 0) ? DELAY - 1 : 0);
   localparam logic [CW-1:0] CAP_LAST = CW'(TRACE_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_CAPTURE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             trig_q;
   logic [ADC_W-1:0] adc_q;

   logic [ADC_W:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      fifo_cnt;
   logic [AW+1:0]    held;
   logic [ADC_W:0]   rd_word;

   logic trig_edge, space_ok, accept, miss;
   logic wr_en, wr_last, out_load, fifo_empty, pop, bypass, push;

   // Offset-binary sample to the 16-bit output format.
   function automatic logic [15:0] fmt(input logic [ADC_W-1:0] s);
`ifdef DAS_TRACE_CAPTURE_SIGNED_EN
      return {{(16-ADC_W){~s[ADC_W-1]}}, ~s[ADC_W-1], s[ADC_W-2:0]};
`else
      return {{(16-ADC_W){1'b0}}, s};
`endif
   endfunction

   // Admission counts everything still held (FIFO plus output register);
   // in IDLE no capture writes are outstanding, so this covers pending ones.
   assign held       = {1'b0, fifo_cnt} + {{(AW+1){1'b0}}, m_valid_o};
   assign space_ok   = (32'(held) + TRACE_LEN) <= FIFO_DEPTH;
   assign trig_edge  = trig_i & ~trig_q;
   assign accept     = trig_edge & (state == S_IDLE) & space_ok;
   assign miss       = trig_edge & ~accept;

   // Capture writes the one-cycle-delayed sample, so CAPTURE cycles line up
   // exactly with the samples t+DELAY .. t+DELAY+TRACE_LEN-1.
   assign wr_en      = (state == S_CAPTURE);
   assign wr_last    = wr_en & (cnt == '0);

   // Output register refills from the FIFO head, or straight from the write
   // when the FIFO is empty, which keeps first-sample latency at two cycles.
   assign out_load   = ~m_valid_o | m_ready_i;
   assign fifo_empty = (fifo_cnt == '0);
   assign pop        = out_load & ~fifo_empty;
   assign bypass     = out_load & fifo_empty & wr_en;
   assign push       = wr_en & ~bypass;
   assign rd_word    = mem[rd_ptr];
   assign busy_o     = (state != S_IDLE);

   // Trigger edge detect, sample delay, capture FSM and miss counter.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state           <= S_IDLE;
         cnt             <= '0;
         trig_q          <= 1'b0;
         adc_q           <= '0;
         trig_miss_cnt_o <= '0;
      end else begin
         trig_q <= trig_i;
         adc_q  <= adc_data_i;
         if (miss && trig_miss_cnt_o != 16'hFFFF)
            trig_miss_cnt_o <= trig_miss_cnt_o + 16'd1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (DELAY == 0) begin
                     state <= S_CAPTURE;
                     cnt   <= CAP_LAST;
                  end else begin
                     state <= S_DELAY;
                     cnt   <= DLY_LAST;
                  end
               end
            end
            S_DELAY: begin
               if (cnt == '0) begin
                  state <= S_CAPTURE;
                  cnt   <= CAP_LAST;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_CAPTURE: begin
               if (cnt == '0) state <= S_IDLE;
               else           cnt   <= cnt - CW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage: sample plus last flag; contents need no reset.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {wr_last, adc_q};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Registered output stage; holds data and last while stalled.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_last_o  <= 1'b0;
      end else if (out_load) begin
         if (pop) begin
            m_valid_o <= 1'b1;
            m_data_o  <= fmt(rd_word[ADC_W-1:0]);
            m_last_o  <= rd_word[ADC_W];
         end else if (bypass) begin
            m_valid_o <= 1'b1;
            m_data_o  <= fmt(adc_q);
            m_last_o  <= wr_last;
         end else begin
            m_valid_o <= 1'b0;
         end
      end
   end

endmodule
